// File: rtl/ff_comb_filter_pkg.sv
// Shared constants and types for the comb / allpass filter family.
package ff_comb_filter_pkg;

    // Fractional bits carried by every sample and gain word.
    localparam int FIXED_POINT = 8;

    typedef enum logic [1:0] {IDLE, RD, MUL, ADD} ff_comb_state_t;

    function automatic int word_bits(input int width);
        return width + FIXED_POINT;
    endfunction

endpackage

// File: rtl/ff_comb_filter_delay_ram.sv
// Simple dual-port sample history RAM: one write port, one registered read port.
module ff_comb_filter_delay_ram #(
    parameter int WORD     = 32,
    parameter int MAXDELAY = 4096,
    localparam int AW      = $clog2(MAXDELAY)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic signed [WORD-1:0] wdata,
    input  logic                   re,
    input  logic [AW-1:0]          raddr,
    output logic signed [WORD-1:0] rdata
);

    logic signed [WORD-1:0] mem [MAXDELAY];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ff_comb_filter.sv
// Feedforward comb filter: out = in + gain * in[n - tau], one sample per four clocks.
module ff_comb_filter
    import ff_comb_filter_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int MAXDELAY = 4096,
    localparam int WORD    = WIDTH + FIXED_POINT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sample_en,
    input  logic signed [WORD-1:0] in,
    input  logic [WORD-1:0]        tau,
    input  logic signed [WORD-1:0] gain,
    input  logic                   write,
    output logic signed [WORD-1:0] out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int AW = $clog2(MAXDELAY);
    localparam int PW = 2 * WORD;
    localparam int SW = WORD + 1;
    localparam logic [AW:0] FILL_MAX = (AW + 1)'(MAXDELAY);

    function automatic logic [AW-1:0] tau_clamp(input logic [WIDTH-1:0] ip);
        int v;
        v = int'($signed(ip));
        if (v < 1) return AW'(1);
        if (v > MAXDELAY - 1) return AW'(MAXDELAY - 1);
        return AW'(v);
    endfunction

    function automatic logic signed [PW-1:0] mul_full(input logic signed [WORD-1:0] a,
                                                      input logic signed [WORD-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return p;
    endfunction

    function automatic logic signed [WORD-1:0] saturate(input logic signed [SW-1:0] s);
        if (s[WORD] != s[WORD-1]) begin
            return s[WORD] ? {1'b1, {(WORD-1){1'b0}}} : {1'b0, {(WORD-1){1'b1}}};
        end
        return s[WORD-1:0];
    endfunction

    ff_comb_state_t state, state_nxt;

    logic [AW-1:0]          wr_ptr, tau_r, pend_tau, tau_in_c, tau_eff, rd_addr;
    logic [AW:0]            fill;
    logic signed [WORD-1:0] gain_r, pend_gain, rd_data, x_p0, d_masked;
    logic signed [SW-1:0]   prod_p1, sum;
    logic                   pend_vld, rd_en, wr_en;
    logic                   unused_tau_frac;

    assign unused_tau_frac = ^tau[FIXED_POINT-1:0];
    assign tau_in_c        = tau_clamp(tau[WORD-1:FIXED_POINT]);

    // A write coinciding with sample_en in IDLE already steers this sample's read.
    assign tau_eff  = write ? tau_in_c : tau_r;
    assign rd_addr  = wr_ptr - tau_eff;
    assign rd_en    = (state == IDLE) && sample_en;
    assign wr_en    = (state == ADD);
    assign busy     = (state != IDLE);
    assign d_masked = (fill < {1'b0, tau_r}) ? '0 : rd_data;
    assign sum      = {x_p0[WORD-1], x_p0} + prod_p1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_en) state_nxt = RD;
            RD:      state_nxt = MUL;
            MUL:     state_nxt = ADD;
            ADD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // p0: sample latched in IDLE; p1: scaled tap product formed in RD.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            x_p0 <= in;
        end
        if (state == RD) begin
            prod_p1 <= SW'(mul_full(gain_r, d_masked) >>> FIXED_POINT);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            wr_ptr    <= '0;
            fill      <= '0;
            tau_r     <= AW'(1);
            gain_r    <= '0;
            pend_tau  <= '0;
            pend_gain <= '0;
            pend_vld  <= 1'b0;
        end else begin
            // Result registered at the end of MUL so it is presented during ADD.
            out_valid <= (state == MUL);
            if (state == MUL) begin
                out <= saturate(sum);
            end
            if (state == ADD) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != FILL_MAX) begin
                    fill <= fill + (AW + 1)'(1);
                end
            end
            if (sample_en && busy) begin
                overrun <= 1'b1;
            end

            if (state == IDLE) begin
                if (write) begin
                    tau_r  <= tau_in_c;
                    gain_r <= gain;
                end
            end else if (state == ADD) begin
                if (write) begin
                    tau_r  <= tau_in_c;
                    gain_r <= gain;
                end else if (pend_vld) begin
                    tau_r  <= pend_tau;
                    gain_r <= pend_gain;
                end
                pend_vld <= 1'b0;
            end else if (write) begin
                pend_tau  <= tau_in_c;
                pend_gain <= gain;
                pend_vld  <= 1'b1;
            end
        end
    end

    ff_comb_filter_delay_ram #(
        .WORD     (WORD),
        .MAXDELAY (MAXDELAY)
    ) u_delay_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (x_p0),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    a_en_known: assert property (@(posedge clk) disable iff (!rstn) !$isunknown(sample_en));
    a_in_known: assert property (@(posedge clk) disable iff (!rstn) sample_en |-> !$isunknown(in));

endmodule
